mult_div_unit: RTL
==================

Name: mult_div_unit

Overview:
Iterative multiply/divide unit in the multicycle datapath. It consumes the A/B operand registers, which are latched from the register-file read ports, and produces the HI/LO result registers. One operation runs at a time with a Start/Busy/Done handshake. The controller stalls on Busy, and mfhi/mflo read HI/LO directly.

Parameters:
- WIDTH, 32, operand width; HI and LO are WIDTH bits each.
- CNT_W, 6, iteration-counter width; must hold the value WIDTH.

Ports:
- CLK  input  1  clock; all state updates on posedge.
- RSTN  input  1  synchronous active-low reset.
- Start  input  1  request a new operation; sampled only when Busy=0.
- Op  input  2  operation select: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- A  input  WIDTH  multiplicand / dividend.
- B  input  WIDTH  multiplier / divisor.
- HI  output  WIDTH  MULT: upper product word; DIV: remainder.
- LO  output  WIDTH  MULT: lower product word; DIV: quotient.
- Busy  output  1  operation in progress.
- Done  output  1  one-cycle pulse; HI/LO hold the new result.

Behaviour:
- Reset is synchronous on RSTN=0 at a posedge CLK, and has priority over everything else.
  - HI=0, LO=0, Busy=0, Done=0, state=IDLE, counter=0.
  - Reset mid-operation aborts it: no Done pulse, and HI/LO are cleared.
- States: IDLE, RUN, FIX, DONE.
  - Busy=1 only in RUN and FIX.
  - Done=1 only in DONE.
- IDLE or DONE with Start=1 (edge t0):
  - Latch Op and the sign flags.
  - Latch the operand magnitudes: |A| and |B| for the signed ops, raw A and B for the unsigned ops.
  - Clear the 2*WIDTH working register, set counter=0, go to RUN.
  - Without Start: DONE->IDLE, IDLE stays IDLE.
- RUN (edges t1..tWIDTH): one iteration per edge, counter+1; after the WIDTH-th iteration go to FIX.
  - Multiply: shift-add, LSB-first.
  - Divide: restoring, MSB-first, using a WIDTH+1-bit trial subtract.
- FIX (edge tWIDTH+1): write HI/LO, go to DONE.
  - MULT: negate the 64-bit product if the sign of A differs from the sign of B.
  - DIV: negate the quotient if the signs differ; the remainder takes the sign of the dividend (truncate toward zero).
- Latency: Start at edge t0 gives valid HI/LO plus Done=1 in the cycle after edge t33 (WIDTH=32), i.e. 34 cycles.
- Start while Busy=1 is ignored: no queueing, and the operands are not re-sampled.
- Start in DONE starts a new operation back-to-back; Done still drops after one cycle.
- HI/LO hold their last result until the next FIX or reset; they are never altered during RUN.
- Divide by zero (B=0), any divide Op: HI=A as presented at t0, LO=all ones. The full iteration still runs, so latency is unchanged.
- Overflow case DIV 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0. No trap is raised.
- Magnitude of 0x80000000 is treated as unsigned 0x80000000; no overflow is flagged.
- Op and A/B may change freely after t0.

Optional Feature:
Macro MD_DIVZERO_FLAG_EN.
- Defined:
  - Adds output port DivZero (1 bit).
  - DivZero is set at the FIX edge when a divide Op was started with B=0.
  - It is cleared at the FIX edge of any other operation and by reset.
  - It is valid together with Done and held until the next FIX.
- Undefined: the port is absent. HI/LO divide-by-zero values are identical in both builds.

Test Plan:
- MULT, A=0xFFFFFFFE, B=0x3, Start pulse -> after 34 cycles Done=1, HI=0xFFFFFFFF, LO=0xFFFFFFFA; Busy high for exactly 33 cycles.
- MULTU with the same operands -> HI=0x00000002, LO=0xFFFFFFFA.
- DIV A=0xFFFFFFF9 (-7), B=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU A=100, B=7 -> LO=0x0000000E, HI=0x00000002.
- DIVU A=0x12345678, B=0 -> HI=0x12345678, LO=0xFFFFFFFF. With MD_DIVZERO_FLAG_EN, DivZero=1; then DIVU 100/7 -> DivZero=0.
- Start asserted again at cycle 10 of a MULT with different A/B -> ignored, and the original result is produced. Start in the Done cycle -> the next op's Busy rises on the following edge.
- RSTN=0 for one edge at cycle 15 of a DIV -> next cycle Busy=0, Done=0, HI=0, LO=0, and no Done pulse follows.

Source files
------------

// File: rtl/mult_div_unit_if.sv
// Start/Busy/Done handshake bundle for mult_div_unit; the DivZero member exists
// only when MD_DIVZERO_FLAG_EN is defined.
interface mult_div_unit_if #(
    parameter int WIDTH = 32
);
    logic             Start;
    logic [1:0]       Op;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [WIDTH-1:0] HI;
    logic [WIDTH-1:0] LO;
    logic             Busy;
    logic             Done;
`ifdef MD_DIVZERO_FLAG_EN
    logic             DivZero;

    modport master (output Start, Op, A, B, input HI, LO, Busy, Done, DivZero);
    modport slave  (input Start, Op, A, B, output HI, LO, Busy, Done, DivZero);
`else
    modport master (output Start, Op, A, B, input HI, LO, Busy, Done);
    modport slave  (input Start, Op, A, B, output HI, LO, Busy, Done);
`endif
endinterface

// File: rtl/mult_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU: one bit per cycle, 34 cycles Start-to-Done, Start ignored while Busy.
// Optional feature macro MD_DIVZERO_FLAG_EN adds the DivZero result flag.
module mult_div_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic            CLK,
    input  logic            RSTN,
    mult_div_unit_if.slave  md
);
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX, S_DONE} state_t;

    state_t               r_state;
    logic [1:0]           r_op;
    logic                 r_neg_q;
    logic                 r_neg_r;
    logic                 r_bzero;
    logic [WIDTH-1:0]     r_a;
    logic [WIDTH-1:0]     r_b;
    logic [WIDTH-1:0]     r_a_raw;
    logic [2*WIDTH-1:0]   r_work;
    logic [CNT_W-1:0]     r_cnt;
    logic [WIDTH-1:0]     r_hi;
    logic [WIDTH-1:0]     r_lo;
    logic                 r_busy;
    logic                 r_done;
    logic                 r_dz;

    // Signed ops have Op[0]=0; unsigned operands never count as negative.
    logic                 w_a_neg;
    logic                 w_b_neg;
    logic [WIDTH-1:0]     w_a_mag;
    logic [WIDTH-1:0]     w_b_mag;
    assign w_a_neg = md.A[WIDTH-1] & ~md.Op[0];
    assign w_b_neg = md.B[WIDTH-1] & ~md.Op[0];
    assign w_a_mag = w_a_neg ? -md.A : md.A;
    assign w_b_mag = w_b_neg ? -md.B : md.B;

    // Multiply: accumulate into the upper half and shift the whole register right.
    logic [WIDTH:0]       w_madd;
    logic [2*WIDTH-1:0]   w_mul_next;
    assign w_madd     = {1'b0, r_work[2*WIDTH-1:WIDTH]} + (r_b[0] ? {1'b0, r_a} : '0);
    assign w_mul_next = {w_madd, r_work[WIDTH-1:1]};

    // Divide: remainder in the upper half, quotient bits shift into the lower half.
    logic [WIDTH:0]       w_part;
    logic [WIDTH:0]       w_trial;
    logic                 w_ge;
    logic [2*WIDTH-1:0]   w_div_next;
    assign w_part     = {r_work[2*WIDTH-1:WIDTH], r_a[WIDTH-1]};
    assign w_trial    = w_part - {1'b0, r_b};
    assign w_ge       = ~w_trial[WIDTH];
    assign w_div_next = {(w_ge ? w_trial[WIDTH-1:0] : w_part[WIDTH-1:0]),
                         r_work[WIDTH-2:0], w_ge};

    logic [2*WIDTH-1:0]   w_prod_fix;
    logic [WIDTH-1:0]     w_q_fix;
    logic [WIDTH-1:0]     w_r_fix;
    assign w_prod_fix = r_neg_q ? -r_work : r_work;
    assign w_q_fix    = r_neg_q ? -r_work[WIDTH-1:0] : r_work[WIDTH-1:0];
    assign w_r_fix    = r_neg_r ? -r_work[2*WIDTH-1:WIDTH] : r_work[2*WIDTH-1:WIDTH];

    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            r_state <= S_IDLE;
            r_op    <= '0;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
            r_bzero <= 1'b0;
            r_a     <= '0;
            r_b     <= '0;
            r_a_raw <= '0;
            r_work  <= '0;
            r_cnt   <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_dz    <= 1'b0;
        end else begin
            unique case (r_state)
                S_IDLE, S_DONE: begin
                    r_done <= 1'b0;
                    if (md.Start) begin
                        r_op    <= md.Op;
                        r_neg_q <= w_a_neg ^ w_b_neg;
                        r_neg_r <= w_a_neg;
                        r_bzero <= (md.B == '0);
                        r_a     <= w_a_mag;
                        r_b     <= w_b_mag;
                        r_a_raw <= md.A;
                        r_work  <= '0;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= S_RUN;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_RUN: begin
                    if (r_op[1]) begin
                        r_work <= w_div_next;
                        r_a    <= r_a << 1;
                    end else begin
                        r_work <= w_mul_next;
                        r_b    <= r_b >> 1;
                    end
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == CNT_W'(WIDTH - 1)) begin
                        r_state <= S_FIX;
                    end
                end
                S_FIX: begin
                    if (!r_op[1]) begin
                        r_hi <= w_prod_fix[2*WIDTH-1:WIDTH];
                        r_lo <= w_prod_fix[WIDTH-1:0];
                    end else if (r_bzero) begin
                        r_hi <= r_a_raw;
                        r_lo <= '1;
                    end else begin
                        r_hi <= w_r_fix;
                        r_lo <= w_q_fix;
                    end
                    r_dz    <= r_op[1] & r_bzero;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                    r_state <= S_DONE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign md.HI   = r_hi;
    assign md.LO   = r_lo;
    assign md.Busy = r_busy;
    assign md.Done = r_done;
`ifdef MD_DIVZERO_FLAG_EN
    assign md.DivZero = r_dz;
`else
    logic w_dz_unused;
    assign w_dz_unused = r_dz;
`endif
endmodule
